// File: rtl/mg_output_serializer_pkg.sv
// Shared constants for the response serializer: sync byte, packet lengths, state encodings.
package mg_output_serializer_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hCD;
  localparam int         PKT_LEN_BASE  = 17;
  localparam int         PKT_LEN_CSUM  = 18;
  localparam int         IDX_W         = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN_BASE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } state_e;

endpackage

// File: rtl/mg_output_serializer_byte_mux.sv
// mg_byte_mux: combinational pick of payload byte sel_i (big-endian status, count, address, data).
module mg_byte_mux (
  input  logic [31:0] status_i,
  input  logic [27:0] count_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [7:0]  byte_o
);

  logic [127:0] payload;

  assign payload = {status_i, 4'h0, count_i, address_i, data_i};

  always_comb begin
    byte_o = payload[8*(15 - int'(sel_i)) +: 8];
  end

endmodule

// File: rtl/mg_output_serializer.sv
// Captures one-cycle master responses and streams them as SYNC + 16 payload bytes, first byte one cycle after out_en.
// MG_OUT_CHECKSUM_EN appends an XOR checksum byte of payload bytes; out_en while busy is dropped and sets sticky overflow.
module mg_output_serializer
  import mg_output_serializer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             out_en,
  input  logic [31:0]      out_status,
  input  logic [31:0]      out_address,
  input  logic [31:0]      out_data,
  input  logic [27:0]      out_data_count,
  output logic             out_ready,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] packets_sent
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        status_q;
  logic [31:0]        address_q;
  logic [31:0]        data_q;
  logic [27:0]        count_q;
  logic               out_ready_q;
  logic               tx_valid_q;
  logic [7:0]         tx_byte_q;
  logic               overflow_q;
  logic [CNT_W-1:0]   packets_q;
  logic [CNT_W-1:0]   packets_d;
  logic [7:0]         mux_byte;
  logic               tx_fire;
`ifdef MG_OUT_CHECKSUM_EN
  logic [7:0]         csum_q;
  logic [7:0]         csum_d;
`endif

  assign tx_fire   = tx_valid_q && tx_ready;
  assign packets_d = packets_q + CNT_W'(1);
`ifdef MG_OUT_CHECKSUM_EN
  // SYNC (idx 0) is excluded from the running XOR.
  assign csum_d    = (idx_q == '0) ? csum_q : (csum_q ^ tx_byte_q);
`endif

  mg_byte_mux u_byte_mux (
    .status_i  (status_q),
    .count_i   (count_q),
    .address_i (address_q),
    .data_i    (data_q),
    .sel_i     (idx_q[3:0]),
    .byte_o    (mux_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      status_q    <= '0;
      address_q   <= '0;
      data_q      <= '0;
      count_q     <= '0;
      out_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
      overflow_q  <= 1'b0;
      packets_q   <= '0;
`ifdef MG_OUT_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      if (out_en && (state_q != ST_IDLE)) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (out_en) begin
            status_q    <= out_status;
            address_q   <= out_address;
            data_q      <= out_data;
            count_q     <= out_data_count;
            state_q     <= ST_SEND;
            idx_q       <= '0;
            tx_valid_q  <= 1'b1;
            tx_byte_q   <= SYNC_BYTE;
            out_ready_q <= 1'b0;
`ifdef MG_OUT_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
          end
        end
        ST_SEND: begin
          if (tx_fire) begin
`ifdef MG_OUT_CHECKSUM_EN
            csum_q <= csum_d;
`endif
            if (idx_q == LAST_IDX) begin
`ifdef MG_OUT_CHECKSUM_EN
              state_q     <= ST_CSUM;
              tx_byte_q   <= csum_d;
`else
              state_q     <= ST_IDLE;
              tx_valid_q  <= 1'b0;
              out_ready_q <= 1'b1;
              packets_q   <= packets_d;
`endif
            end else begin
              // Mux select idx yields packet byte idx+1, so the next byte is ready without a bubble.
              idx_q     <= idx_q + IDX_W'(1);
              tx_byte_q <= mux_byte;
            end
          end
        end
`ifdef MG_OUT_CHECKSUM_EN
        ST_CSUM: begin
          if (tx_fire) begin
            state_q     <= ST_IDLE;
            tx_valid_q  <= 1'b0;
            out_ready_q <= 1'b1;
            packets_q   <= packets_d;
          end
        end
`endif
        default: begin
          state_q     <= ST_IDLE;
          tx_valid_q  <= 1'b0;
          out_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_ready    = out_ready_q;
  assign tx_valid     = tx_valid_q;
  assign tx_byte      = tx_byte_q;
  assign overflow     = overflow_q;
  assign packets_sent = packets_q;

endmodule
